// File: rtl/serial_word_receiver_if.sv
// Bundle of serial input and recovered-word outputs between the serial link
// and the word receiver. The master drives SI; the slave returns the word and flags.
interface serial_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             SI;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             parity_err;
  logic             frame_err;
  logic             busy;

  modport master (
    output SI,
    input  dout, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  SI,
    output dout, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_word_receiver.sv
// LSB-first serial frame receiver: start(1), WIDTH data bits, optional even
// parity, stop(0). Presents the word with a one-cycle valid pulse and error flags.
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  serial_word_receiver_if.slave bus
);
  localparam int                CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WIDTH - 1);
  localparam logic              PAR_ON = (PARITY_EN != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             par_bit;
  logic [WIDTH-1:0] dout_r;
  logic             valid_r;
  logic             perr_r;
  logic             ferr_r;
  logic             busy_r;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic parity_fail(input logic [WIDTH-1:0] w, input logic p);
    return PAR_ON & ((^w) ^ p);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      dout_r  <= '0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.SI) begin
            state  <= DATA;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        DATA: begin
          sr <= {bus.SI, sr[WIDTH-1:1]};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= PAR_ON ? PARITY : STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          par_bit <= bus.SI;
          state   <= STOP;
        end
        STOP: begin
          // SI here is the stop bit only; it never starts a new frame.
          dout_r  <= sr;
          valid_r <= 1'b1;
          perr_r  <= parity_fail(sr, par_bit);
          ferr_r  <= bus.SI;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.valid      = valid_r;
  assign bus.parity_err = perr_r;
  assign bus.frame_err  = ferr_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: parity and no-parity instances
// share one serial line; a select picks which instance is observed.
module tb_serial_word_receiver;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic si   = 1'b0;
  bit   sel  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WIDTH(4)) if_p ();
  serial_word_receiver_if #(.WIDTH(4)) if_np ();

  assign if_p.SI  = si;
  assign if_np.SI = si;

  serial_word_receiver #(.WIDTH(4), .PARITY_EN(1)) u_p (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if_p.slave)
  );

  serial_word_receiver #(.WIDTH(4), .PARITY_EN(0)) u_np (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if_np.slave)
  );

  logic [3:0] o_dout;
  logic       o_valid, o_perr, o_ferr, o_busy;
  assign o_dout  = sel ? if_np.dout       : if_p.dout;
  assign o_valid = sel ? if_np.valid      : if_p.valid;
  assign o_perr  = sel ? if_np.parity_err : if_p.parity_err;
  assign o_ferr  = sel ? if_np.frame_err  : if_p.frame_err;
  assign o_busy  = sel ? if_np.busy       : if_p.busy;

  typedef struct packed {
    logic [3:0] d;      // data bits, d[0] sent first
    logic       par;
    logic       stop;
    logic [3:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},  32'(o_dout),  32'h0);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_perr"},  32'(o_perr),  32'h0);
    chk({tag, "_ferr"},  32'(o_ferr),  32'h0);
    chk({tag, "_busy"},  32'(o_busy),  32'h0);
  endtask

  task automatic send(input logic [3:0] d, input logic par, input logic stop,
                      input bit use_par, input logic [3:0] ed, input logic ep,
                      input logic ef, input int id);
    int busy_n;
    busy_n = 0;
    si = 1'b1;
    tick();
    if (o_busy) busy_n++;
    chk($sformatf("f%0d_valid_start", id), 32'(o_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      si = d[i];
      tick();
      if (o_busy) busy_n++;
      chk($sformatf("f%0d_valid_d%0d", id, i), 32'(o_valid), 32'h0);
    end
    if (use_par) begin
      si = par;
      tick();
      if (o_busy) busy_n++;
      chk($sformatf("f%0d_valid_par", id), 32'(o_valid), 32'h0);
    end
    si = stop;
    tick();
    chk($sformatf("f%0d_valid", id), 32'(o_valid), 32'h1);
    chk($sformatf("f%0d_busy_stop", id), 32'(o_busy), 32'h0);
    chk($sformatf("f%0d_dout", id), 32'(o_dout), 32'(ed));
    chk($sformatf("f%0d_perr", id), 32'(o_perr), 32'(ep));
    chk($sformatf("f%0d_ferr", id), 32'(o_ferr), 32'(ef));
    chk($sformatf("f%0d_busy_cycles", id), 32'(busy_n), use_par ? 32'd6 : 32'd5);
    si = 1'b0;
    tick();
    chk($sformatf("f%0d_valid_idle", id), 32'(o_valid), 32'h0);
    chk($sformatf("f%0d_busy_idle", id), 32'(o_busy), 32'h0);
    chk($sformatf("f%0d_dout_hold", id), 32'(o_dout), 32'(ed));
  endtask

  initial begin
    //            d        par   stop  dout   perr  ferr
    tbl[0] = '{4'b1101, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0};
    tbl[1] = '{4'b1101, 1'b0, 1'b0, 4'hD, 1'b1, 1'b0};
    tbl[2] = '{4'b1101, 1'b1, 1'b1, 4'hD, 1'b0, 1'b1};
    tbl[3] = '{4'b0000, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[4] = '{4'b0010, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0};
    tbl[5] = '{4'b1111, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0};

    // Reset state, then an idle line
    #3;
    chk_all_zero("reset");
    #9 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle%0d_busy", i),  32'(o_busy),  32'h0);
      chk($sformatf("idle%0d_valid", i), 32'(o_valid), 32'h0);
      chk($sformatf("idle%0d_dout", i),  32'(o_dout),  32'h0);
    end

    // Table frames on the parity instance, one idle cycle between each
    for (int k = 0; k < 6; k++)
      send(tbl[k].d, tbl[k].par, tbl[k].stop, 1'b1,
           tbl[k].exp_dout, tbl[k].exp_perr, tbl[k].exp_ferr, k);

    // Reset mid-frame after two data bits clears everything without a clock
    si = 1'b1; tick();
    si = 1'b0; tick();
    si = 1'b0; tick();
    chk("midrst_busy_before", 32'(o_busy), 32'h1);
    chk("midrst_dout_before", 32'(o_dout), 32'hF);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    #2 rstn = 1'b1;
    si = 1'b0;
    tick();
    chk("midrst_idle_busy", 32'(o_busy), 32'h0);
    send(4'b0100, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 7);

    // No-parity instance
    sel = 1'b1;
    tick(); tick();
    chk("np_idle_busy", 32'(o_busy), 32'h0);
    send(4'b0011, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
